decode_stage_ctrl: RTL and testbench

Decode-stage sequencer for the 5-stage RV32I pipeline. Owns the IF/ID and ID/EX pipeline registers, decodes the instruction held in ID, drives the sign-extend unit's `In`/`ImmSrc` inputs, and captures its `ImmExt` result into EX. It also detects load-use hazards (stall plus bubble) and applies taken-branch/jump flushes.

---
 rtl/decode_stage_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_decode_stage_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl: RV32I decode-stage sequencer.
// Owns the IF/ID and ID/EX pipeline registers and decodes the instruction
// held in ID. It detects load-use hazards, which cause a one-cycle stall plus
// a bubble. It also applies taken-branch/jump flushes.
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to mark unsupported
// encodings with IllegalE as they pass through EX.
// No handshakes: every register advances each cycle unless stalled or flushed.
module decode_stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    input  logic        PCSrcE,
    input  logic [31:0] ImmExtD,
    output logic        StallF,
    output logic [31:0] InstrD,
    output logic [1:0]  ImmSrcD,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic [1:0]  ResultSrcE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic [2:0]  Funct3E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [31:0] ImmExtE,
    output logic        IllegalE
);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [2:0]  ALU_ADD   = 3'b000;
    localparam logic [2:0]  ALU_SUB   = 3'b001;
    localparam logic [2:0]  ALU_AND   = 3'b010;
    localparam logic [2:0]  ALU_OR    = 3'b011;
    localparam logic [2:0]  ALU_SLT   = 3'b101;

    logic [31:0] pcD, pcPlus4D;
    logic [6:0]  opcode;
    logic [2:0]  funct3D;
    logic [4:0]  rdD;
    logic        regWriteD, memWriteD, jumpD, branchD, aluSrcD;
    logic [1:0]  resultSrcD;
    logic [2:0]  aluControlD, aluFunctD;
    logic        useRs1, useRs2;
    logic        lwStall, squashE;

    assign opcode  = InstrD[6:0];
    assign funct3D = InstrD[14:12];
    assign rdD     = InstrD[11:7];
    assign Rs1D    = InstrD[19:15];
    assign Rs2D    = InstrD[24:20];

    // ALU operation selected by funct3 for the R-type and I-ALU groups.
    always_comb begin
        aluFunctD = ALU_ADD;
        case (funct3D)
            3'b000:  aluFunctD = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  aluFunctD = ALU_SLT;
            3'b110:  aluFunctD = ALU_OR;
            3'b111:  aluFunctD = ALU_AND;
            default: aluFunctD = ALU_ADD;
        endcase
    end

    // Main opcode decode; unknown opcodes leave every control at zero.
    always_comb begin
        regWriteD   = 1'b0;
        resultSrcD  = 2'b00;
        memWriteD   = 1'b0;
        jumpD       = 1'b0;
        branchD     = 1'b0;
        aluSrcD     = 1'b0;
        ImmSrcD     = 2'b00;
        aluControlD = ALU_ADD;
        useRs1      = 1'b0;
        useRs2      = 1'b0;
        case (opcode)
            OP_LOAD: begin
                regWriteD  = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = 2'b01;
                useRs1     = 1'b1;
            end
            OP_STORE: begin
                ImmSrcD   = 2'b01;
                aluSrcD   = 1'b1;
                memWriteD = 1'b1;
                useRs1    = 1'b1;
                useRs2    = 1'b1;
            end
            OP_R: begin
                regWriteD   = 1'b1;
                aluControlD = aluFunctD;
                useRs1      = 1'b1;
                useRs2      = 1'b1;
            end
            OP_I: begin
                regWriteD   = 1'b1;
                aluSrcD     = 1'b1;
                aluControlD = aluFunctD;
                useRs1      = 1'b1;
            end
            OP_BRANCH: begin
                ImmSrcD     = 2'b10;
                branchD     = 1'b1;
                aluControlD = ALU_SUB;
                useRs1      = 1'b1;
                useRs2      = 1'b1;
            end
            OP_JAL: begin
                regWriteD  = 1'b1;
                ImmSrcD    = 2'b11;
                resultSrcD = 2'b10;
                jumpD      = 1'b1;
            end
            default: ;
        endcase
    end

    // A load in EX whose destination is read by the ID instruction must wait a cycle.
    assign lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((useRs1 && Rs1D == RdE) || (useRs2 && Rs2D == RdE));
    // A flush discards the fetch anyway, so it wins over the stall.
    assign StallF  = lwStall && !PCSrcE;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegalD;
    assign illegalD = !(opcode == OP_LOAD || opcode == OP_STORE || opcode == OP_R ||
                        opcode == OP_I || opcode == OP_BRANCH || opcode == OP_JAL) ||
                      ((opcode == OP_R || opcode == OP_I) &&
                       !(funct3D == 3'b000 || funct3D == 3'b010 ||
                         funct3D == 3'b110 || funct3D == 3'b111));
    assign squashE = lwStall || PCSrcE || illegalD;

    // Illegal marker rides with its bubble; flush and stall bubbles clear it.
    always_ff @(posedge clk) begin
        if (rst || PCSrcE || lwStall) IllegalE <= 1'b0;
        else                          IllegalE <= illegalD;
    end
`else
    assign squashE  = lwStall || PCSrcE;
    assign IllegalE = 1'b0;
`endif

    // IF/ID register: flush inserts a NOP, a load-use stall holds the entry.
    always_ff @(posedge clk) begin
        if (rst || PCSrcE) begin
            InstrD   <= NOP;
            pcD      <= 32'd0;
            pcPlus4D <= 32'd0;
        end else if (!lwStall) begin
            InstrD   <= InstrF;
            pcD      <= PCF;
            pcPlus4D <= PCPlus4F;
        end
    end

    // ID/EX register: loads the decoded bundle or an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || squashE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= 3'b000;
            Funct3E     <= 3'b000;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
            PCE         <= 32'd0;
            PCPlus4E    <= 32'd0;
            ImmExtE     <= 32'd0;
        end else begin
            RegWriteE   <= regWriteD;
            ResultSrcE  <= resultSrcD;
            MemWriteE   <= memWriteD;
            JumpE       <= jumpD;
            BranchE     <= branchD;
            ALUSrcE     <= aluSrcD;
            ALUControlE <= aluControlD;
            Funct3E     <= funct3D;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= rdD;
            PCE         <= pcD;
            PCPlus4E    <= pcPlus4D;
            ImmExtE     <= ImmExtD;
        end
    end
endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Bench for decode_stage_ctrl: directed instruction stream, a pipeline-level
// reference model checked every cycle, and hand-computed literal checkpoints.
module tb_decode_stage_ctrl;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADDI5 = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] LW5   = 32'h0000_A283; // lw x5,0(x1)
    localparam logic [31:0] ADD6  = 32'h0022_8333; // add x6,x5,x2
    localparam logic [31:0] LW0   = 32'h0000_A003; // lw x0,0(x1)
    localparam logic [31:0] ADDX0 = 32'h0020_0333; // add x6,x0,x2
    localparam logic [31:0] JAL8  = 32'h0080_00EF; // jal x1,8
    localparam logic [31:0] SUB7  = 32'h4023_03B3; // sub x7,x6,x2
    localparam logic [31:0] SW4   = 32'h0020_A223; // sw x2,4(x1)
    localparam logic [31:0] BEQ16 = 32'h0020_8863; // beq x1,x2,16
    localparam logic [31:0] ILL   = 32'h0000_007F;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst, PCSrcE, StallF;
    logic [31:0] InstrF, PCF, PCPlus4F, ImmExtD, InstrD;
    logic [1:0]  ImmSrcD, ResultSrcE;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
    logic [2:0]  ALUControlE, Funct3E;
    logic [31:0] PCE, PCPlus4E, ImmExtE;

    int checks = 0;
    int errors = 0;
    logic [31:0] pcCnt;

    decode_stage_ctrl dut (
        .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .PCSrcE(PCSrcE), .ImmExtD(ImmExtD), .StallF(StallF), .InstrD(InstrD),
        .ImmSrcD(ImmSrcD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE),
        .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .Funct3E(Funct3E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .IllegalE(IllegalE)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- sign-extend unit (external to the DUT) ----------------
    function automatic logic [31:0] sext(input logic [31:0] i, input logic [1:0] src);
        case (src)
            2'b00:   sext = {{20{i[31]}}, i[31:20]};
            2'b01:   sext = {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   sext = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            default: sext = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction
    assign ImmExtD = sext(InstrD, ImmSrcD);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic        memWrite, jump, branch, aluSrc;
        logic [2:0]  aluControl, funct3;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pc4, imm;
        logic        illegal;
    } ex_t;

    // Control table rows: {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump}
    function automatic logic [8:0] ctlRow(input logic [6:0] op);
        case (op)
            7'b0000011: ctlRow = {1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
            7'b0100011: ctlRow = {1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
            7'b0110011: ctlRow = {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
            7'b0010011: ctlRow = {1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
            7'b1100011: ctlRow = {1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
            7'b1101111: ctlRow = {1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};
            default:    ctlRow = 9'd0;
        endcase
    endfunction

    function automatic logic isAluGroup(input logic [31:0] i);
        return (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0010011);
    endfunction

    function automatic logic [2:0] aluOf(input logic [31:0] i);
        logic [2:0] f3;
        f3 = i[14:12];
        if (i[6:0] == 7'b1100011) return 3'b001;
        if (!isAluGroup(i)) return 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b000 && i[6:0] == 7'b0110011 && i[30]) return 3'b001;
        return 3'b000;
    endfunction

    // {rs1 used, rs2 used}
    function automatic logic [1:0] usesOf(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011:              usesOf = 2'b10;
            7'b0100011, 7'b0110011, 7'b1100011: usesOf = 2'b11;
            default:                             usesOf = 2'b00;
        endcase
    endfunction

    function automatic logic isIllegal(input logic [31:0] i);
        logic [2:0] f3;
        f3 = i[14:12];
        if (ctlRow(i[6:0]) == 9'd0) return 1'b1;
        return isAluGroup(i) && !(f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    logic [31:0] mInstrD, mPcD, mPc4D;
    ex_t         mE;
    logic        modelOn = 1'b0;

    function automatic logic modelStall();
        logic [1:0] u;
        u = usesOf(mInstrD[6:0]);
        return (mE.resultSrc == 2'b01) && (mE.rd != 5'd0) &&
               ((u[1] && mInstrD[19:15] == mE.rd) || (u[0] && mInstrD[24:20] == mE.rd));
    endfunction

    always @(posedge clk) begin
        ex_t        nE;
        logic [8:0] row;
        logic       stall;
        if (rst) begin
            mInstrD <= NOP;
            mPcD    <= 32'd0;
            mPc4D   <= 32'd0;
            mE      <= '0;
            modelOn <= 1'b1;
        end else begin
            stall = modelStall();
            row   = ctlRow(mInstrD[6:0]);
            nE    = '0;
            if (PCSrcE || stall) begin
                nE = '0;
            end else if (TRAP && isIllegal(mInstrD)) begin
                nE.illegal = 1'b1;
            end else begin
                nE.regWrite   = row[8];
                nE.aluSrc     = row[5];
                nE.memWrite   = row[4];
                nE.resultSrc  = row[3:2];
                nE.branch     = row[1];
                nE.jump       = row[0];
                nE.aluControl = aluOf(mInstrD);
                nE.funct3     = mInstrD[14:12];
                nE.rs1        = mInstrD[19:15];
                nE.rs2        = mInstrD[24:20];
                nE.rd         = mInstrD[11:7];
                nE.pc         = mPcD;
                nE.pc4        = mPc4D;
                nE.imm        = sext(mInstrD, row[7:6]);
            end
            mE <= nE;
            if (PCSrcE) begin
                mInstrD <= NOP;
                mPcD    <= 32'd0;
                mPc4D   <= 32'd0;
            end else if (!stall) begin
                mInstrD <= InstrF;
                mPcD    <= PCF;
                mPc4D   <= PCPlus4F;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle after reset: DUT outputs against the model.
    always @(negedge clk) begin
        logic [8:0] row;
        if (modelOn) begin
            row = ctlRow(mInstrD[6:0]);
            chk("InstrD", InstrD, mInstrD);
            chk("ImmSrcD", {30'd0, ImmSrcD}, {30'd0, row[7:6]});
            chk("RsD", {22'd0, Rs1D, Rs2D}, {22'd0, mInstrD[19:15], mInstrD[24:20]});
            chk("StallF", {31'd0, StallF}, {31'd0, modelStall() && !PCSrcE});
            chk("ctlE", {20'd0, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
                         ALUControlE, IllegalE},
                        {20'd0, mE.regWrite, mE.resultSrc, mE.memWrite, mE.jump, mE.branch,
                         mE.aluSrc, mE.aluControl, mE.illegal});
            chk("regsE", {14'd0, Funct3E, Rs1E, Rs2E, RdE},
                         {14'd0, mE.funct3, mE.rs1, mE.rs2, mE.rd});
            chk("PCE", PCE, mE.pc);
            chk("PCPlus4E", PCPlus4E, mE.pc4);
            chk("ImmExtE", ImmExtE, mE.imm);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [31:0] instr, input logic pcsrc);
        @(posedge clk);
        #1;
        InstrF   = instr;
        PCF      = pcCnt;
        PCPlus4F = pcCnt + 32'd4;
        PCSrcE   = pcsrc;
        pcCnt    = pcCnt + 32'd4;
    endtask

    logic [31:0] tail [12] = '{
        32'h7FF0_E193, // ori  x3,x1,0x7ff
        32'hFFF1_F213, // andi x4,x3,-1
        32'h0041_A2B3, // slt  x5,x3,x4
        32'h0041_E2B3, // or   x5,x3,x4
        32'hFE51_2E23, // sw   x5,-4(x2)
        32'h0082_A383, // lw   x7,8(x5)
        32'h0070_2023, // sw   x7,0(x0): rs2 hazard
        32'h1234_52B7, // lui (unsupported)
        32'h0082_A383, // lw   x7,8(x5)
        32'h0073_8863, // beq  x7,x7,16: hazard
        32'hFFDF_F0EF, // jal  x1,-4
        NOP
    };

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; InstrF = ADDI5; PCF = 32'h100; PCPlus4F = 32'h104; PCSrcE = 1'b0;
        pcCnt = 32'h104;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_InstrD", InstrD, NOP);
        chk("rst_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        chk("rst_PCE", PCE, 32'd0);
        chk("rst_ImmExtE", ImmExtE, 32'd0);
        chk("rst_StallF", {31'd0, StallF}, 32'd0);

        drive(LW5, 1'b0);   @(negedge clk);
        chk("addi_InstrD", InstrD, ADDI5);
        drive(ADD6, 1'b0);  @(negedge clk);
        chk("addi_RegWriteE", {31'd0, RegWriteE}, 32'd1);
        chk("addi_ALUSrcE", {31'd0, ALUSrcE}, 32'd1);
        chk("addi_ImmExtE", ImmExtE, 32'd5);
        chk("addi_PCE", PCE, 32'h100);
        drive(NOP, 1'b0);   @(negedge clk);
        chk("lu_StallF", {31'd0, StallF}, 32'd1);
        chk("lu_ResultSrcE", {30'd0, ResultSrcE}, 32'd1);
        drive(LW0, 1'b0);   @(negedge clk);
        chk("lu_hold_InstrD", InstrD, ADD6);
        chk("lu_bubble_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        chk("lu_after_StallF", {31'd0, StallF}, 32'd0);
        drive(ADDX0, 1'b0); @(negedge clk);
        chk("lu_issue_Rs1E", {27'd0, Rs1E}, 32'd5);
        chk("lu_issue_RdE", {27'd0, RdE}, 32'd6);
        drive(LW5, 1'b0);   @(negedge clk);
        chk("x0_StallF", {31'd0, StallF}, 32'd0);
        drive(JAL8, 1'b0);  @(negedge clk);
        drive(SUB7, 1'b0);  @(negedge clk);
        chk("jal_StallF", {31'd0, StallF}, 32'd0);
        chk("jal_ImmSrcD", {30'd0, ImmSrcD}, 32'd3);
        drive(SW4, 1'b0);   @(negedge clk);
        chk("jal_JumpE", {31'd0, JumpE}, 32'd1);
        chk("jal_ResultSrcE", {30'd0, ResultSrcE}, 32'd2);
        chk("jal_ImmExtE", ImmExtE, 32'd8);
        drive(BEQ16, 1'b0); @(negedge clk);
        chk("sub_ALUControlE", {29'd0, ALUControlE}, 32'd1);
        chk("sw_ImmSrcD", {30'd0, ImmSrcD}, 32'd1);
        drive(SUB7, 1'b0);  @(negedge clk);
        chk("beq_ImmSrcD", {30'd0, ImmSrcD}, 32'd2);
        chk("sw_MemWriteE", {31'd0, MemWriteE}, 32'd1);
        chk("sw_ImmExtE", ImmExtE, 32'd4);
        drive(ADDI5, 1'b1); @(negedge clk);
        chk("fl_BranchE", {31'd0, BranchE}, 32'd1);
        chk("fl_InstrD", InstrD, SUB7);
        drive(LW5, 1'b0);   @(negedge clk);
        chk("fl_nop_InstrD", InstrD, NOP);
        chk("fl_bubble_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        chk("fl_bubble_PCE", PCE, 32'd0);
        chk("fl_StallF", {31'd0, StallF}, 32'd0);

        // Flush forced together with a load-use stall.
        drive(ADD6, 1'b0);  @(negedge clk);
        drive(NOP, 1'b1);   @(negedge clk);
        chk("flst_StallF", {31'd0, StallF}, 32'd0);
        drive(LW5, 1'b0);   @(negedge clk);
        chk("flst_InstrD", InstrD, NOP);
        chk("flst_RegWriteE", {31'd0, RegWriteE}, 32'd0);

        // Reset arriving mid-stall.
        drive(ADD6, 1'b0);  @(negedge clk);
        drive(NOP, 1'b0);   @(negedge clk);
        chk("rs_StallF", {31'd0, StallF}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rs_InstrD", InstrD, NOP);
        chk("rs_ResultSrcE", {30'd0, ResultSrcE}, 32'd0);
        chk("rs_StallF", {31'd0, StallF}, 32'd0);

        // Unsupported opcode.
        drive(ILL, 1'b0);   @(negedge clk);
        drive(NOP, 1'b0);   @(negedge clk);
        chk("ill_ImmSrcD", {30'd0, ImmSrcD}, 32'd0);
        drive(NOP, 1'b0);   @(negedge clk);
        chk("ill_IllegalE", {31'd0, IllegalE}, {31'd0, TRAP});
        chk("ill_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        drive(NOP, 1'b0);   @(negedge clk);
        chk("ill_clear_IllegalE", {31'd0, IllegalE}, 32'd0);

        // Mixed directed stream checked by the model.
        for (int i = 0; i < 12; i++) drive(tail[i], 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        drive(32'h0041_C2B3, 1'b0); // xor: unsupported funct3
`endif
        repeat (4) drive(NOP, 1'b0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
